// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: PC source encodings,
// FSM state encodings, the NOP word and the default reset PC.
package if_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  // Next-PC source selected by branch/jump resolution
  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pc_src_e;

  // FETCH: request at PC; HOLD: instruction buffered while stalled;
  // DRAIN: waiting out a response that was orphaned by a redirect
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DRAIN = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_pc_target_sel.sv
// Next-PC target mux: picks sequential PC+4 or one of the three redirect
// targets according to PC_Src. Purely combinational.
module pc_target_sel
  import if_fetch_stage_pkg::*;
(
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] target
);

  // 4:1 select of the next PC candidate
  always_comb begin
    target = pc_plus4;
    case (pc_src)
      PCSRC_BR: target = branch_target;
      PCSRC_J:  target = jump_target;
      PCSRC_JR: target = jr_target;
      default:  target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests
// over a ready handshake and hands instruction + PC+4 to IF_ID, emitting a
// NOP bubble whenever no instruction is available.
// Optional feature: define FETCH_PERF_CNT_EN to add the bubble_cnt output.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_Write,
  input  logic [1:0]  PC_Src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic        fetch_valid,
  output logic [31:0] instruction_out,
  output logic [31:0] PC_NEXT_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);

  fetch_state_e state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  req_addr_reg;
  logic [31:0]  buf_instr_reg;
  logic [31:0]  buf_pcnext_reg;

  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_pc;
  logic         redirect;

  // PC+4 wraps naturally at 2^32
  assign pc_plus4 = pc_reg + 32'd4;
  // A redirect from a stalled stage is ignored; that stage re-presents it
  assign redirect = (PC_Src != PCSRC_SEQ) && PC_Write;
  assign PC_out   = pc_reg;

  pc_target_sel u_target_sel (
    .pc_src        (PC_Src),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .target        (redirect_pc)
  );

  // Request and delivery outputs; delivery is combinational from imem_rdata
  always_comb begin
    imem_req        = 1'b0;
    imem_addr       = pc_reg;
    fetch_valid     = 1'b0;
    instruction_out = NOP_WORD;
    PC_NEXT_out     = 32'h0;
    case (state_reg)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && !redirect) begin
          fetch_valid     = 1'b1;
          instruction_out = imem_rdata;
          PC_NEXT_out     = pc_plus4;
        end
      end
      ST_HOLD: begin
        if (!redirect) begin
          fetch_valid     = 1'b1;
          instruction_out = buf_instr_reg;
          PC_NEXT_out     = buf_pcnext_reg;
        end
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_reg;
      end
      default: ;
    endcase
  end

  // Fetch FSM: PC update, stall buffering and redirect draining
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_FETCH;
      pc_reg         <= RESET_PC;
      req_addr_reg   <= 32'h0;
      buf_instr_reg  <= NOP_WORD;
      buf_pcnext_reg <= 32'h0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (imem_ready) begin
            if (redirect) begin
              pc_reg <= redirect_pc;
            end else if (PC_Write) begin
              pc_reg <= pc_plus4;
            end else begin
              buf_instr_reg  <= imem_rdata;
              buf_pcnext_reg <= pc_plus4;
              state_reg      <= ST_HOLD;
            end
          end else if (redirect) begin
            // Outstanding request must complete before the target is issued
            req_addr_reg <= pc_reg;
            pc_reg       <= redirect_pc;
            state_reg    <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            pc_reg    <= redirect_pc;
            state_reg <= ST_FETCH;
          end else if (PC_Write) begin
            pc_reg    <= pc_plus4;
            state_reg <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (redirect) begin
            pc_reg <= redirect_pc;
          end
          if (imem_ready) begin
            state_reg <= ST_FETCH;
          end
        end
        default: state_reg <= ST_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;

  // Count every non-reset cycle that delivers a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_reg <= 32'h0;
    end else if (!fetch_valid) begin
      bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage with a scoreboard of expected
// instruction/PC+4 pairs. Define FETCH_PERF_CNT_EN to also check bubble_cnt.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        PC_Write;
  logic [1:0]  PC_Src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic        fetch_valid;
  logic [31:0] instruction_out;
  logic [31:0] PC_NEXT_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_bubbles = 0;
  logic [63:0] sb_q[$];

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .PC_Write        (PC_Write),
    .PC_Src          (PC_Src),
    .branch_target   (branch_target),
    .jump_target     (jump_target),
    .jr_target       (jr_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .PC_out          (PC_out),
    .fetch_valid     (fetch_valid),
    .instruction_out (instruction_out),
    .PC_NEXT_out     (PC_NEXT_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .bubble_cnt      (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // then advance past the rising edge.
  task automatic step(input logic rdy, input logic pcw, input logic [1:0] src,
                      input logic exp_req, input logic [31:0] exp_addr,
                      input logic exp_fv);
    logic [31:0] exp_pcn;
    imem_ready = rdy;
    PC_Write   = pcw;
    PC_Src     = src;
    imem_rdata = rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    exp_pcn    = exp_addr + 32'd4;
    if (exp_fv && exp_req) sb_q.push_back({mem_word(exp_addr), exp_pcn});
    if (!exp_fv) n_bubbles++;
    @(negedge clk);
    chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
    chk("fetch_valid", {31'h0, fetch_valid}, {31'h0, exp_fv});
    if (exp_fv) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL scoreboard: observed valid output %h with empty queue, expected none", instruction_out);
      end else begin
        chk("instruction_out", instruction_out, sb_q[0][63:32]);
        chk("PC_NEXT_out", PC_NEXT_out, sb_q[0][31:0]);
        $display("xfer instr=%h pc_next=%h consumed=%0d", instruction_out, PC_NEXT_out, pcw);
        if (pcw) void'(sb_q.pop_front());
      end
    end else begin
      chk("bubble_instr", instruction_out, 32'h0);
      chk("bubble_pcnext", PC_NEXT_out, 32'h0);
      if (!exp_req && sb_q.size() > 0) void'(sb_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    PC_Write = 1'b1;
    PC_Src = 2'b00;
    branch_target = 32'h0;
    jump_target = 32'h0;
    jr_target = 32'h0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_pc", PC_out, 32'h0);

    // Reset state: request at RESET_PC, bubble output
    step(1'b0, 1'b1, 2'b00, 1'b1, 32'h0, 1'b0);

    // Zero-wait memory: one instruction per cycle
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h0,  1'b1);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h4,  1'b1);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h8,  1'b1);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'hC,  1'b1);

    // Ready every third cycle: two bubbles between instructions
    step(1'b0, 1'b1, 2'b00, 1'b1, 32'h10, 1'b0);
    step(1'b0, 1'b1, 2'b00, 1'b1, 32'h10, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h10, 1'b1);
    step(1'b0, 1'b1, 2'b00, 1'b1, 32'h14, 1'b0);
    step(1'b0, 1'b1, 2'b00, 1'b1, 32'h14, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h14, 1'b1);

    // Stall on a ready cycle: HOLD presents the same instruction 4 cycles
    step(1'b1, 1'b0, 2'b00, 1'b1, 32'h18, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b0, 32'h18, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b0, 32'h18, 1'b1);
    step(1'b0, 1'b1, 2'b00, 1'b0, 32'h18, 1'b1);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h1C, 1'b1);

    // Branch while waiting: DRAIN the old request, then fetch the target
    branch_target = 32'h0000_0100;
    step(1'b0, 1'b1, 2'b01, 1'b1, 32'h20, 1'b0);
    step(1'b0, 1'b1, 2'b00, 1'b1, 32'h20, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h20, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h100, 1'b1);

    // jr on a ready cycle: response dropped, target fetched next
    jr_target = 32'h0000_0080;
    step(1'b1, 1'b1, 2'b11, 1'b1, 32'h104, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h80,  1'b1);

    // Jump while in HOLD: buffered instruction is discarded
    jump_target = 32'h0000_0040;
    step(1'b1, 1'b0, 2'b00, 1'b1, 32'h84, 1'b1);
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h84, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h40, 1'b1);

    // Redirect while stalled is ignored
    branch_target = 32'h0000_0300;
    step(1'b0, 1'b0, 2'b01, 1'b1, 32'h44, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h44, 1'b1);

    // PC wrap: 0xFFFF_FFFC + 4 = 0
    jump_target = 32'hFFFF_FFFC;
    step(1'b1, 1'b1, 2'b10, 1'b1, 32'h48, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h0, 1'b1);

    imem_ready = 1'b0;
    @(negedge clk);
    chk("final_pc", PC_out, 32'h4);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("bubble_cnt", bubble_cnt, n_bubbles);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage pipelined CPU: holds the PC, issues requests to instruction memory over a ready handshake, and presents the fetched instruction with its PC+4 to the IF_ID pipeline register. It accepts redirects from branch/jump resolution and stalls from the hazard unit. When no instruction is available it emits a bubble (instruction 0 = NOP).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- PC_Write  in  1  hazard unit; 0 = stall: hold PC, hold any fetched instruction
- PC_Src  in  2  00 sequential, 01 branch_target, 10 jump_target, 11 jr_target
- branch_target / jump_target / jr_target  in  32 each  redirect addresses
- imem_req  out  1  fetch request
- imem_addr  out  32  request address, stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  response valid this cycle (imem_rdata valid)
- imem_rdata  in  32  fetched word
- PC_out  out  32  current PC register
- fetch_valid  out  1  instruction_out/PC_NEXT_out carry a real instruction
- instruction_out  out  32  to IF_ID instruction_in; 0 when fetch_valid=0
- PC_NEXT_out  out  32  to IF_ID PC_NEXT_in; 0 when fetch_valid=0

## Operation
- Registers: PC, req_addr, buf_instr, buf_pcnext, state.
- States: FETCH (req=1, addr=PC), HOLD (instruction buffered, req=0), DRAIN (req=1, addr=req_addr, response will be discarded).
- Redirect = PC_Src!=00 AND PC_Write=1. Redirect with PC_Write=0 is ignored (source stage is stalled and re-presents it).
- FETCH, imem_ready=1, no redirect: fetch_valid=1, instruction_out=imem_rdata, PC_NEXT_out=PC+4. PC_Write=1 → PC<=PC+4, stay FETCH. PC_Write=0 → buf<=data/PC+4, go HOLD.
- FETCH, imem_ready=1, redirect: response dropped (fetch_valid=0), PC<=target, stay FETCH.
- FETCH, imem_ready=0, redirect: req_addr<=PC, PC<=target, go DRAIN.
- FETCH, imem_ready=0, no redirect: fetch_valid=0, hold.
- HOLD: fetch_valid=1, outputs from buffer. PC_Write=1 and no redirect → PC<=PC+4, go FETCH. Redirect → buffer dropped (fetch_valid=0 that cycle), PC<=target, go FETCH. PC_Write=0 → stay.
- DRAIN: fetch_valid=0; imem_ready=1 → go FETCH. A further redirect in DRAIN updates PC only.
- PC+4 wraps modulo 2^32; targets used as-is (no alignment check).

## Timing
- Reset: PC=RESET_PC, state=FETCH, buffers 0; so imem_req=1, imem_addr=RESET_PC, fetch_valid=0, instruction_out=0, PC_NEXT_out=0 in the first cycle after reset.
- Delivery is combinational from imem_rdata in the imem_ready cycle; IF_ID captures it at the same edge. Zero-wait memory gives one instruction per cycle.
- Redirect takes effect at the next edge; first fetch from target issues the following cycle (one-cycle bubble minimum).
- rst mid-request: state to FETCH immediately; any pending response is not tracked (memory must also be reset).

## Configuration
- FETCH_PERF_CNT_EN defined: adds output bubble_cnt (32 bits), reset to 0, incremented each cycle fetch_valid=0 and rst=0; wraps.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package: PC_Src encodings (PCSRC_SEQ/BR/J/JR), NOP word 32'h0, state encodings, RESET_PC default.
- One sub-module: pc_target_sel (combinational 4:1 target mux driven by PC_Src).

## Test plan
- Reset, imem_ready tied 1, PC_Write=1 → imem_addr 0,4,8,...; PC_NEXT_out 4,8,12 with fetch_valid=1 each cycle from the first.
- imem_ready=1 every 3rd cycle → two bubbles (instruction_out=0) between valid instructions; PC advances only on ready.
- PC_Write=0 for 3 cycles on a ready cycle → HOLD, imem_req=0, same instruction/PC_NEXT presented 4 cycles, then PC+4 fetched.
- Redirect PC_Src=01, branch_target=0x100 while waiting (ready=0) → DRAIN; old response discarded; next imem_addr=0x100, first valid PC_NEXT_out=0x104.
- Redirect in HOLD (PC_Src=10, jump_target=0x40) → buffered instruction never valid again; next fetch 0x40.
- PC=0xFFFF_FFFC, ready=1 → PC_NEXT_out=0, next imem_addr=0; with FETCH_PERF_CNT_EN bubble_cnt counts exact bubble cycles of scenario 2.
